// File: rtl/inst_pkg.sv
// Shared definitions for the instruction sequencer: field widths and positions,
// source index encodings, FSM state type and a saturating counter helper.
package inst_pkg;

    localparam int INST_W = 8;
    localparam int OPC_W  = 2;
    localparam int SRC0_W = 2;
    localparam int SRC1_W = 2;
    localparam int DST0_W = 1;
    localparam int DST1_W = 1;

    // Fields are packed from the LSB upward: dst1, dst0, src1, src0, opcode.
    localparam int DST1_LSB = 0;
    localparam int DST0_LSB = DST1_LSB + DST1_W;
    localparam int SRC1_LSB = DST0_LSB + DST0_W;
    localparam int SRC0_LSB = SRC1_LSB + SRC1_W;
    localparam int OPC_LSB  = SRC0_LSB + SRC0_W;

    localparam logic [1:0] SRC_INT  = 2'd0;
    localparam logic [1:0] SRC_NIN  = 2'd1;
    localparam logic [1:0] SRC_REG  = 2'd2;
    localparam logic [1:0] SRC_ZERO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_EXEC = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/inst_ready_chk.sv
// Issue check: an instruction may issue only when every FIFO source it reads
// holds data and every destination it writes has room.
module inst_ready_chk
    import inst_pkg::*;
#(
    parameter int S0W = SRC0_W,
    parameter int S1W = SRC1_W
) (
    input  logic [S0W-1:0] i_src0,
    input  logic [S1W-1:0] i_src1,
    input  logic           i_dst0,
    input  logic           i_dst1,
    input  logic           i_int_empty,
    input  logic           i_nin_empty,
    input  logic           i_nout_full,
    input  logic           i_bus_full,
    output logic           o_ready,
    output logic           o_int_deq,
    output logic           o_nin_deq
);

    logic w_need_int;
    logic w_need_nin;

    // Both operands naming the same FIFO share one pop.
    assign w_need_int = (i_src0 == S0W'(SRC_INT)) || (i_src1 == S1W'(SRC_INT));
    assign w_need_nin = (i_src0 == S0W'(SRC_NIN)) || (i_src1 == S1W'(SRC_NIN));

    assign o_ready = !(w_need_int && i_int_empty) &&
                     !(w_need_nin && i_nin_empty) &&
                     !(i_dst0 && i_nout_full) &&
                     !(i_dst1 && i_bus_full);

    assign o_int_deq = o_ready && w_need_int;
    assign o_nin_deq = o_ready && w_need_nin;

endmodule

// File: rtl/inst_sequencer.sv
// Fetches instructions from the control FIFO, waits for operands and result space,
// then issues one ALU op per instruction. Optional perf counters: INST_SEQUENCER_PERF_EN.
module inst_sequencer
    import inst_pkg::*;
#(
    parameter int INST_WIDTH     = INST_W,
    parameter int OPCODE_WIDTH   = OPC_W,
    parameter int SRC0_IDX_WIDTH = SRC0_W,
    parameter int SRC1_IDX_WIDTH = SRC1_W,
    parameter int DST0_IDX_WIDTH = DST0_W,
    parameter int DST1_IDX_WIDTH = DST1_W
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      ctrl_fifo_deq,
    input  logic [INST_WIDTH-1:0]     ctrl_fifo_data_out,
    input  logic                      ctrl_fifo_empty,
    output logic                      int_fifo_deq,
    output logic                      nin_fifo_deq,
    input  logic                      int_fifo_empty,
    input  logic                      nin_fifo_empty,
    output logic                      nout_fifo_enq,
    output logic                      bus_fifo_enq,
    input  logic                      nout_fifo_full,
    input  logic                      bus_fifo_full,
    output logic                      alu_valid,
    output logic [OPCODE_WIDTH-1:0]   alu_op,
    output logic [SRC0_IDX_WIDTH-1:0] src0_sel,
    output logic [SRC1_IDX_WIDTH-1:0] src1_sel,
    output logic                      busy
`ifdef INST_SEQUENCER_PERF_EN
    ,
    output logic [15:0]               perf_inst_cnt,
    output logic [15:0]               perf_stall_cnt
`endif
);

    localparam int L_D1 = 0;
    localparam int L_D0 = L_D1 + DST1_IDX_WIDTH;
    localparam int L_S1 = L_D0 + DST0_IDX_WIDTH;
    localparam int L_S0 = L_S1 + SRC1_IDX_WIDTH;
    localparam int L_OP = L_S0 + SRC0_IDX_WIDTH;

    state_t                    r_state;
    logic [INST_WIDTH-1:0]     r_inst;
    logic                      r_run;
    logic                      r_alu_valid;
    logic                      r_nout_enq;
    logic                      r_bus_enq;
    logic [OPCODE_WIDTH-1:0]   r_alu_op;
    logic [SRC0_IDX_WIDTH-1:0] r_src0_sel;
    logic [SRC1_IDX_WIDTH-1:0] r_src1_sel;
    logic                      r_busy;

    logic [OPCODE_WIDTH-1:0]   w_opc;
    logic [SRC0_IDX_WIDTH-1:0] w_src0;
    logic [SRC1_IDX_WIDTH-1:0] w_src1;
    logic                      w_dst0;
    logic                      w_dst1;
    logic                      w_ready;
    logic                      w_int_deq;
    logic                      w_nin_deq;
    logic                      w_ctrl_deq;

    assign w_opc  = r_inst[L_OP +: OPCODE_WIDTH];
    assign w_src0 = r_inst[L_S0 +: SRC0_IDX_WIDTH];
    assign w_src1 = r_inst[L_S1 +: SRC1_IDX_WIDTH];
    assign w_dst0 = |r_inst[L_D0 +: DST0_IDX_WIDTH];
    assign w_dst1 = |r_inst[L_D1 +: DST1_IDX_WIDTH];

    inst_ready_chk #(
        .S0W (SRC0_IDX_WIDTH),
        .S1W (SRC1_IDX_WIDTH)
    ) u_ready_chk (
        .i_src0      (w_src0),
        .i_src1      (w_src1),
        .i_dst0      (w_dst0),
        .i_dst1      (w_dst1),
        .i_int_empty (int_fifo_empty),
        .i_nin_empty (nin_fifo_empty),
        .i_nout_full (nout_fifo_full),
        .i_bus_full  (bus_fifo_full),
        .o_ready     (w_ready),
        .o_int_deq   (w_int_deq),
        .o_nin_deq   (w_nin_deq)
    );

    // r_run holds off the first fetch until one clock has passed after reset release.
    assign w_ctrl_deq = !ctrl_fifo_empty &&
                        (((r_state == ST_IDLE) && r_run) || (r_state == ST_EXEC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_inst      <= '0;
            r_run       <= 1'b0;
            r_alu_valid <= 1'b0;
            r_nout_enq  <= 1'b0;
            r_bus_enq   <= 1'b0;
            r_alu_op    <= '0;
            r_src0_sel  <= '0;
            r_src1_sel  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_alu_valid <= 1'b0;
            r_nout_enq  <= 1'b0;
            r_bus_enq   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ctrl_deq) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_inst  <= ctrl_fifo_data_out;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_ready) begin
                        r_state     <= ST_EXEC;
                        r_alu_valid <= 1'b1;
                        r_nout_enq  <= w_dst0;
                        r_bus_enq   <= w_dst1;
                        r_alu_op    <= w_opc;
                        r_src0_sel  <= w_src0;
                        r_src1_sel  <= w_src1;
                    end
                end
                ST_EXEC: begin
                    if (w_ctrl_deq) begin
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_fifo_deq = w_ctrl_deq;
    assign int_fifo_deq  = (r_state == ST_WAIT) && w_int_deq;
    assign nin_fifo_deq  = (r_state == ST_WAIT) && w_nin_deq;
    assign nout_fifo_enq = r_nout_enq;
    assign bus_fifo_enq  = r_bus_enq;
    assign alu_valid     = r_alu_valid;
    assign alu_op        = r_alu_op;
    assign src0_sel      = r_src0_sel;
    assign src1_sel      = r_src1_sel;
    assign busy          = r_busy;

`ifdef INST_SEQUENCER_PERF_EN
    logic [15:0] r_perf_inst;
    logic [15:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_inst  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_state == ST_EXEC)
                r_perf_inst <= sat_inc16(r_perf_inst);
            if ((r_state == ST_WAIT) && !w_ready)
                r_perf_stall <= sat_inc16(r_perf_stall);
        end
    end

    assign perf_inst_cnt  = r_perf_inst;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: a control FIFO model feeds instructions and a
// scoreboard of expected ALU issues is checked whenever alu_valid is seen.
module tb_inst_sequencer;
    import inst_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ctrl_fifo_deq;
    logic [7:0] ctrl_fifo_data_out = '0;
    logic       ctrl_fifo_empty;
    logic       int_fifo_deq, nin_fifo_deq;
    logic       int_fifo_empty = 1'b0, nin_fifo_empty = 1'b0;
    logic       nout_fifo_enq, bus_fifo_enq;
    logic       nout_fifo_full = 1'b0, bus_fifo_full = 1'b0;
    logic       alu_valid;
    logic [1:0] alu_op, src0_sel, src1_sel;
    logic       busy;
`ifdef INST_SEQUENCER_PERF_EN
    logic [15:0] perf_inst_cnt, perf_stall_cnt;
    logic [15:0] p0;
`endif

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] s0;
        logic [1:0] s1;
        logic       n;
        logic       b;
        logic [1:0] ipc;
        logic [1:0] npc;
    } exp_t;

    exp_t sb[$];
    logic [7:0] inst_mem [0:63];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_pushed = 0, n_popped = 0;
    int ipc = 0, npc = 0, last_deq = 0, alu_cyc = 0, prev = 0, c0 = 0;
    logic alu_seen = 1'b0;

    inst_sequencer dut (
        .clk                (clk),
        .reset              (reset),
        .ctrl_fifo_deq      (ctrl_fifo_deq),
        .ctrl_fifo_data_out (ctrl_fifo_data_out),
        .ctrl_fifo_empty    (ctrl_fifo_empty),
        .int_fifo_deq       (int_fifo_deq),
        .nin_fifo_deq       (nin_fifo_deq),
        .int_fifo_empty     (int_fifo_empty),
        .nin_fifo_empty     (nin_fifo_empty),
        .nout_fifo_enq      (nout_fifo_enq),
        .bus_fifo_enq       (bus_fifo_enq),
        .nout_fifo_full     (nout_fifo_full),
        .bus_fifo_full      (bus_fifo_full),
        .alu_valid          (alu_valid),
        .alu_op             (alu_op),
        .src0_sel           (src0_sel),
        .src1_sel           (src1_sel),
        .busy               (busy)
`ifdef INST_SEQUENCER_PERF_EN
        ,
        .perf_inst_cnt      (perf_inst_cnt),
        .perf_stall_cnt     (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Control FIFO model: data appears the cycle after a pop.
    assign ctrl_fifo_empty = (n_pushed == n_popped);
    always @(posedge clk) begin
        if (ctrl_fifo_deq) begin
            ctrl_fifo_data_out <= inst_mem[n_popped[5:0]];
            n_popped <= n_popped + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [7:0] ins);
        exp_t e;
        inst_mem[n_pushed[5:0]] = ins;
        n_pushed++;
        e.op  = ins[OPC_LSB +: OPC_W];
        e.s0  = ins[SRC0_LSB +: SRC0_W];
        e.s1  = ins[SRC1_LSB +: SRC1_W];
        e.n   = ins[DST0_LSB];
        e.b   = ins[DST1_LSB];
        e.ipc = (e.s0 == SRC_INT || e.s1 == SRC_INT) ? 2'd1 : 2'd0;
        e.npc = (e.s0 == SRC_NIN || e.s1 == SRC_NIN) ? 2'd1 : 2'd0;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        logic [11:0] o;
        cyc++;
        if (int_fifo_deq) begin
            chk("int_deq_when_empty", int_fifo_empty, 0);
            ipc++; last_deq = cyc;
        end
        if (nin_fifo_deq) begin
            chk("nin_deq_when_empty", nin_fifo_empty, 0);
            npc++; last_deq = cyc;
        end
        if (nout_fifo_enq) begin
            chk("nout_enq_when_full", nout_fifo_full, 0);
            chk("nout_enq_outside_exec", alu_valid, 1);
        end
        if (bus_fifo_enq) begin
            chk("bus_enq_when_full", bus_fifo_full, 0);
            chk("bus_enq_outside_exec", alu_valid, 1);
        end
        if (alu_valid) begin
            alu_seen = 1'b1;
            alu_cyc  = cyc;
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                o = {alu_op, src0_sel, src1_sel, nout_fifo_enq, bus_fifo_enq, ipc[1:0], npc[1:0]};
                chk("exec_fields", o, e);
                if ((e.ipc | e.npc) != 0)
                    chk("deq_to_exec_cycles", cyc - last_deq, 1);
            end
            ipc = 0; npc = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_alu(input string tag, input int budget);
        alu_seen = 1'b0;
        for (int i = 0; i < budget && !alu_seen; i++) step();
        chk({tag, "_issued"}, alu_seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        chk("reset_strobes", {ctrl_fifo_deq, int_fifo_deq, nin_fifo_deq, nout_fifo_enq,
                              bus_fifo_enq, alu_valid, busy}, 0);
        chk("reset_sels", {alu_op, src0_sel, src1_sel}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(); step();
        chk("idle_after_reset", busy, 0);

        // INT + NIN sources, NOUT destination
        push(8'b00_00_01_10);
        wait_alu("t035", 8);
        chk("t035_idle_after", busy, 0);

        // NIN empty for five WAIT cycles
`ifdef INST_SEQUENCER_PERF_EN
        p0 = perf_stall_cnt;
`endif
        nin_fifo_empty = 1'b1;
        push(8'b00_00_01_10);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("t036_no_deq", {int_fifo_deq, nin_fifo_deq, alu_valid}, 0);
            chk("t036_busy", busy, 1);
            step();
        end
        nin_fifo_empty = 1'b0;
        c0 = cyc;
        wait_alu("t036", 4);
        chk("t036_issue_latency", alu_cyc - c0, 2);
`ifdef INST_SEQUENCER_PERF_EN
        chk("t036_stall_cnt", 16'(perf_stall_cnt - p0), 5);
`endif

        // Same FIFO on both operands, both destinations
        push(8'b01_00_00_11);
        wait_alu("t037", 8);

        // BUS full holds the instruction in WAIT
        bus_fifo_full = 1'b1;
        push(8'b10_01_00_01);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("t038_no_deq_enq", {int_fifo_deq, nin_fifo_deq, nout_fifo_enq, bus_fifo_enq}, 0);
            step();
        end
        bus_fifo_full = 1'b0;
        wait_alu("t038", 4);

        // Ten back-to-back register/zero instructions
`ifdef INST_SEQUENCER_PERF_EN
        p0 = perf_inst_cnt;
`endif
        for (int i = 0; i < 10; i++)
            push({2'(i), (i % 2 == 1) ? SRC_REG : SRC_ZERO,
                  (i % 2 == 1) ? SRC_ZERO : SRC_REG, 1'(i), 1'(i >> 1)});
        for (int i = 0; i < 10; i++) begin
            wait_alu("t039", 8);
            if (i > 0) chk("t039_spacing", alu_cyc - prev, 3);
            prev = alu_cyc;
        end
        chk("t039_ctrl_drained", n_popped == n_pushed, 1);
`ifdef INST_SEQUENCER_PERF_EN
        chk("t039_inst_cnt", 16'(perf_inst_cnt - p0), 10);
`endif

        // Reset asserted while in EXEC
        push(8'b11_00_01_11);
        alu_seen = 1'b0;
        for (int i = 0; i < 10 && !alu_seen; i++) begin
            @(negedge clk);
            monitor();
            if (!alu_seen) begin
                @(posedge clk); #1;
            end
        end
        chk("t040_reached_exec", alu_seen, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t040_strobes", {ctrl_fifo_deq, int_fifo_deq, nin_fifo_deq, nout_fifo_enq,
                             bus_fifo_enq, alu_valid, busy}, 0);
        chk("t040_sels", {alu_op, src0_sel, src1_sel}, 0);
`ifdef INST_SEQUENCER_PERF_EN
        chk("t040_perf", {perf_inst_cnt, perf_stall_cnt}, 0);
`endif
        push(8'b00_10_11_10);
        @(posedge clk); #1;
        chk("t040_held", {ctrl_fifo_deq, alu_valid, busy}, 0);
        reset = 1'b1;
        #1;
        chk("t040_no_deq_at_release", ctrl_fifo_deq, 0);
        wait_alu("t040_resume", 8);

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
